// File: rtl/mdio_pkg.sv
// Shared Clause 22 MDIO frame constants, FSM states and frame helpers.
// The PHY-side responder uses the same encodings.
package mdio_pkg;

    localparam logic [1:0] MDIO_ST       = 2'b01;
    localparam logic [1:0] MDIO_OP_READ  = 2'b10;
    localparam logic [1:0] MDIO_OP_WRITE = 2'b01;
    localparam int         MDIO_PRE_BITS = 32;
    localparam int         MDIO_HDR_BITS = 14;
    localparam int         MDIO_TA_BITS  = 2;
    localparam int         MDIO_DAT_BITS = 16;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_HDR  = 3'd2,
        ST_TA   = 3'd3,
        ST_DATA = 3'd4,
        ST_DONE = 3'd5
    } mdio_state_e;

    // Post-preamble frame image, MSB first. Read frames carry ones in TA/DATA;
    // those positions are never driven because mdo_oe is low there.
    function automatic logic [31:0] mdio_frame(input logic we,
                                               input logic [9:0] addr,
                                               input logic [15:0] data);
        logic [1:0]  op;
        logic [1:0]  ta;
        logic [15:0] dat;
        op  = we ? MDIO_OP_WRITE : MDIO_OP_READ;
        ta  = we ? 2'b10 : 2'b11;
        dat = we ? data : 16'hFFFF;
        return {MDIO_ST, op, addr, ta, dat};
    endfunction

    function automatic logic [5:0] phase_len(input mdio_state_e s);
        logic [5:0] n;
        n = 6'd1;
        case (s)
            ST_PRE:  n = 6'(MDIO_PRE_BITS);
            ST_HDR:  n = 6'(MDIO_HDR_BITS);
            ST_TA:   n = 6'(MDIO_TA_BITS);
            ST_DATA: n = 6'(MDIO_DAT_BITS);
            default: n = 6'd1;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/mdio_master_clkgen.sv
// MDC generator: divider plus mdc register, with single-cycle enables on the
// clk edges that move mdc 0->1 (rise) and 1->0 (fall). Held at zero when idle.
module mdio_master_clkgen #(
    parameter int MDC_DIV = 25
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic mdc,
    output logic rise,
    output logic fall
);

    localparam int CW = (MDC_DIV > 2) ? $clog2(MDC_DIV) : 1;

    logic [CW-1:0] div;
    logic          tc;

    assign tc   = run && (div == CW'(MDC_DIV - 1));
    assign rise = tc && !mdc;
    assign fall = tc && mdc;

    always_ff @(posedge clk) begin
        if (!rst_n || !run) begin
            div <= '0;
            mdc <= 1'b0;
        end else if (tc) begin
            div <= '0;
            mdc <= ~mdc;
        end else begin
            div <= div + 1'b1;
        end
    end

endmodule

// File: rtl/mdio_master.sv
// Clause 22 MDIO initiator: turns Wishbone classic register accesses into
// MDC/MDIO frames toward a PHY and returns read data / PHY-absent errors.
module mdio_master
    import mdio_pkg::*;
#(
    parameter int MDC_DIV  = 25,
    parameter bit PREAMBLE = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cyc,
    input  logic        stb,
    input  logic        we,
    input  logic [9:0]  addr,
    input  logic [15:0] data_write,
    output logic [15:0] data_read,
    output logic        ack,
    output logic        err,
    output logic        mdc,
    output logic        mdo,
    output logic        mdo_oe,
    input  logic        mdi
);

    mdio_state_e state, next;
    logic        run;
    logic        rise, fall;
    logic        accept;
    logic        last_bit;
    logic [31:0] shreg;
    logic [5:0]  bit_cnt;
    logic        we_q;
    logic        ta_bit;
    logic [15:0] rx;

    mdio_master_clkgen #(.MDC_DIV(MDC_DIV)) u_clkgen (
        .clk  (clk),
        .rst_n(rst_n),
        .run  (run),
        .mdc  (mdc),
        .rise (rise),
        .fall (fall)
    );

    // ack/err are still high on the first IDLE cycle; a master that has not yet
    // dropped stb must not start a second frame.
    assign accept   = (state == ST_IDLE) && cyc && stb && !ack && !err;
    assign last_bit = (bit_cnt == phase_len(state) - 6'd1);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= next;
    end

    always_comb begin
        next = state;
        run  = 1'b0;
        case (state)
            ST_IDLE: if (accept) next = PREAMBLE ? ST_PRE : ST_HDR;
            ST_PRE: begin
                run = 1'b1;
                if (fall && last_bit) next = ST_HDR;
            end
            ST_HDR: begin
                run = 1'b1;
                if (fall && last_bit) next = ST_TA;
            end
            ST_TA: begin
                run = 1'b1;
                if (fall && last_bit) next = ST_DATA;
            end
            ST_DATA: begin
                run = 1'b1;
                if (fall && last_bit) next = ST_DONE;
            end
            ST_DONE: next = ST_IDLE;
            default: next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mdo       <= 1'b1;
            mdo_oe    <= 1'b0;
            ack       <= 1'b0;
            err       <= 1'b0;
            data_read <= '0;
            shreg     <= '0;
            bit_cnt   <= '0;
            we_q      <= 1'b0;
            ta_bit    <= 1'b1;
            rx        <= '0;
        end else begin
            ack <= 1'b0;
            err <= 1'b0;

            if (accept) begin
                shreg   <= mdio_frame(we, addr, data_write);
                we_q    <= we;
                bit_cnt <= '0;
                mdo_oe  <= 1'b1;
                mdo     <= PREAMBLE ? 1'b1 : MDIO_ST[1];
            end

            // mdi is registered here, so the sample is the pre-edge pin value.
            if (rise) begin
                if (state == ST_TA && bit_cnt == 6'd1) ta_bit <= mdi;
                if (state == ST_DATA)                  rx     <= {rx[14:0], mdi};
            end

            if (fall) begin
                bit_cnt <= last_bit ? 6'd0 : bit_cnt + 6'd1;
                case (state)
                    ST_PRE: if (last_bit) mdo <= shreg[31];
                    ST_HDR, ST_TA: begin
                        shreg <= shreg << 1;
                        mdo   <= shreg[30];
                        if (state == ST_HDR && last_bit && !we_q) mdo_oe <= 1'b0;
                    end
                    ST_DATA: begin
                        if (last_bit) begin
                            mdo    <= 1'b1;
                            mdo_oe <= 1'b0;
                        end else begin
                            shreg <= shreg << 1;
                            mdo   <= shreg[30];
                        end
                    end
                    default: ;
                endcase
            end

            // Completion is reported only if the bus cycle is still open.
            if (state == ST_DONE && cyc && stb) begin
                if (!we_q && ta_bit) begin
                    err       <= 1'b1;
                    data_read <= 16'hFFFF;
                end else begin
                    ack <= 1'b1;
                    if (!we_q) data_read <= rx;
                end
            end
        end
    end

endmodule

// File: tb/tb_mdio_master.sv
// Bench for mdio_master: behavioural PHY at PHYAD 1, pin capture, and an
// expected-response queue drained by a monitor on every ack/err.
module tb_mdio_master;

    typedef struct {
        logic        err;
        logic        chkd;
        logic [15:0] data;
        int          lat;
        int          t0;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc_n = 0;

    logic cyc0 = 0, stb0 = 0, we0 = 0;
    logic [9:0] addr0 = '0;
    logic [15:0] dw0 = '0, dr0;
    logic ack0, err0, mdc0, mdo0, oe0, mdi0;

    logic cyc1 = 0, stb1 = 0, we1 = 0;
    logic [9:0] addr1 = '0;
    logic [15:0] dw1 = '0, dr1;
    logic ack1, err1, mdc1, mdo1, oe1, mdi1;

    exp_t q0[$];
    exp_t q1[$];
    int   n_chk = 0;
    int   n_fail = 0;

    // PHY model state
    logic [15:0] phy_regs [32];
    logic        phy_oe, phy_out, pm_b, pm_rd, pm_hit, drv_en, drv_val;
    logic [31:0] pm_sh;
    logic [4:0]  pm_reg;
    logic [15:0] pm_data;
    int          pm_ones, pm_pos;

    // Pin captures
    logic [63:0] cap0 = '0;
    int          n0 = 0;
    logic [31:0] cap1 = '0;
    int          n1 = 0, last1 = 0, per1 = 0;

    always #4 clk = ~clk;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    assign mdi0 = oe0 ? mdo0 : (phy_oe ? phy_out : 1'b1);
    assign mdi1 = oe1 ? mdo1 : 1'b1;

    mdio_master u0 (
        .clk(clk), .rst_n(rst_n), .cyc(cyc0), .stb(stb0), .we(we0), .addr(addr0),
        .data_write(dw0), .data_read(dr0), .ack(ack0), .err(err0),
        .mdc(mdc0), .mdo(mdo0), .mdo_oe(oe0), .mdi(mdi0)
    );

    mdio_master #(.MDC_DIV(2), .PREAMBLE(1'b0)) u1 (
        .clk(clk), .rst_n(rst_n), .cyc(cyc1), .stb(stb1), .we(we1), .addr(addr1),
        .data_write(dw1), .data_read(dr1), .ack(ack1), .err(err1),
        .mdc(mdc1), .mdo(mdo1), .mdo_oe(oe1), .mdi(mdi1)
    );

    always @(posedge mdc0) begin
        if (oe0) begin
            cap0 <= {cap0[62:0], mdo0};
            n0   <= n0 + 1;
        end
    end

    always @(posedge mdc1) begin
        if (oe1) begin
            cap1 <= {cap1[30:0], mdo1};
            n1   <= n1 + 1;
        end
        per1  <= cyc_n - last1;
        last1 <= cyc_n;
    end

    // PHY: samples on mdc rise, drives 100 time units after rise.
    initial begin
        for (int i = 0; i < 32; i++) phy_regs[i] = 16'h0000;
        phy_regs[2] = 16'hBEEF;
        phy_oe = 0; phy_out = 1; pm_ones = 0; pm_pos = -1;
        pm_rd = 0; pm_hit = 0; pm_sh = '0; pm_reg = '0; pm_data = '0;
        forever begin
            @(posedge mdc0 or negedge rst_n);
            if (!rst_n) begin
                phy_oe = 0; pm_ones = 0; pm_pos = -1;
            end else begin
                pm_b = mdi0;
                drv_en = 0; drv_val = 1;
                if (pm_pos < 0) begin
                    if (pm_b) pm_ones++;
                    else if (pm_ones >= 32) pm_pos = 0;
                    else pm_ones = 0;
                end
                if (pm_pos >= 0) begin
                    pm_sh = {pm_sh[30:0], pm_b};
                    if (pm_pos == 13) begin
                        pm_rd   = (pm_sh[11:10] == 2'b10);
                        pm_hit  = (pm_sh[9:5] == 5'd1);
                        pm_reg  = pm_sh[4:0];
                        pm_data = phy_regs[pm_sh[4:0]];
                    end
                    if (pm_pos == 31 && !pm_rd && pm_hit) phy_regs[pm_reg] = pm_sh[15:0];
                    if (pm_rd && pm_hit && pm_pos >= 14 && pm_pos <= 30) begin
                        drv_en  = 1;
                        drv_val = (pm_pos == 14) ? 1'b0 : pm_data[30 - pm_pos];
                    end
                    if (pm_pos == 31) begin pm_pos = -1; pm_ones = 0; end
                    else pm_pos++;
                    #100;
                    if (!rst_n) begin
                        phy_oe = 0; pm_ones = 0; pm_pos = -1;
                    end else begin
                        phy_oe = drv_en; phy_out = drv_val;
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic req(input int dut, input logic w, input logic [9:0] a, input logic [15:0] d,
                       input logic push, input logic e_err, input logic chkd, input logic [15:0] ed);
        exp_t e;
        @(negedge clk);
        e = '{err: e_err, chkd: chkd, data: ed, lat: (dut == 0) ? 3202 : 130, t0: cyc_n};
        if (dut == 0) begin
            cyc0 = 1; stb0 = 1; we0 = w; addr0 = a; dw0 = d;
            if (push) q0.push_back(e);
        end else begin
            cyc1 = 1; stb1 = 1; we1 = w; addr1 = a; dw1 = d;
            if (push) q1.push_back(e);
        end
    endtask

    task automatic wait_resp(input int dut, input int budget);
        int k;
        for (k = 0; k < budget; k++) begin
            @(negedge clk);
            if (dut == 0 && (ack0 || err0)) break;
            if (dut == 1 && (ack1 || err1)) break;
        end
        if (k == budget) begin
            n_chk++; n_fail++;
            $display("FAIL timeout_resp%0d actual=none expected=ack_or_err", dut);
        end
        if (dut == 0) begin cyc0 = 0; stb0 = 0; end
        else          begin cyc1 = 0; stb1 = 0; end
    endtask

    task automatic mon_check(input string tag, input logic a, input logic e, input logic [15:0] d,
                             input exp_t x);
        chk({tag, "_ack"}, 64'(a), 64'(!x.err));
        chk({tag, "_err"}, 64'(e), 64'(x.err));
        if (x.chkd) chk({tag, "_data"}, 64'(d), 64'(x.data));
        chk({tag, "_latency"}, 64'(cyc_n - x.t0), 64'(x.lat));
    endtask

    initial begin
        int s;
        fork
            forever begin
                @(negedge clk);
                if (ack0 || err0) begin
                    if (q0.size() == 0) chk("unexpected_resp0", {62'd0, ack0, err0}, 64'd0);
                    else mon_check("resp0", ack0, err0, dr0, q0.pop_front());
                end
                if (ack1 || err1) begin
                    if (q1.size() == 0) chk("unexpected_resp1", {62'd0, ack1, err1}, 64'd0);
                    else mon_check("resp1", ack1, err1, dr1, q1.pop_front());
                end
            end
        join_none

        repeat (5) @(negedge clk);
        chk("rst_mdc0", 64'(mdc0), 0);  chk("rst_mdo0", 64'(mdo0), 1);
        chk("rst_oe0", 64'(oe0), 0);    chk("rst_ack0", 64'(ack0), 0);
        chk("rst_err0", 64'(err0), 0);  chk("rst_data0", 64'(dr0), 0);
        chk("rst_mdc1", 64'(mdc1), 0);  chk("rst_mdo1", 64'(mdo1), 1);
        chk("rst_oe1", 64'(oe1), 0);    chk("rst_ack1", 64'(ack1), 0);
        chk("rst_err1", 64'(err1), 0);  chk("rst_data1", 64'(dr1), 0);
        rst_n = 1;
        repeat (3) @(negedge clk);

        // 1: write PHY 1 reg 0
        s = n0;
        req(0, 1, {5'd1, 5'd0}, 16'h1234, 1, 0, 0, 16'h0);
        wait_resp(0, 4000);
        chk("t1_bits", 64'(n0 - s), 64);
        chk("t1_frame", cap0, {32'hFFFF_FFFF, 2'b01, 2'b01, 5'd1, 5'd0, 2'b10, 16'h1234});
        chk("t1_phyreg0", 64'(phy_regs[0]), 64'h1234);
        repeat (3) @(negedge clk);

        // 2: read PHY 1 reg 2
        s = n0;
        req(0, 0, {5'd1, 5'd2}, 16'h0, 1, 0, 1, 16'hBEEF);
        wait_resp(0, 4000);
        chk("t2_driven_bits", 64'(n0 - s), 46);
        chk("t2_header", 64'(cap0[13:0]), 64'({2'b01, 2'b10, 5'd1, 5'd2}));
        repeat (3) @(negedge clk);

        // 3: read absent PHY 7
        req(0, 0, {5'd7, 5'd1}, 16'h0, 1, 1, 1, 16'hFFFF);
        wait_resp(0, 4000);
        repeat (3) @(negedge clk);

        // 4: no preamble, MDC_DIV=2
        s = n1;
        req(1, 1, {5'd1, 5'd3}, 16'hA5A5, 1, 0, 0, 16'h0);
        wait_resp(1, 300);
        chk("t4_bits", 64'(n1 - s), 32);
        chk("t4_frame", 64'(cap1), 64'({2'b01, 2'b01, 5'd1, 5'd3, 2'b10, 16'hA5A5}));
        chk("t4_mdc_period", 64'(per1), 4);
        repeat (3) @(negedge clk);

        // 5: reset in the DATA phase of a read, then a clean read
        req(0, 0, {5'd1, 5'd2}, 16'h0, 0, 0, 0, 16'h0);
        repeat (2600) @(negedge clk);
        rst_n = 0; cyc0 = 0; stb0 = 0;
        @(negedge clk);
        chk("t5_oe", 64'(oe0), 0);
        chk("t5_mdc", 64'(mdc0), 0);
        chk("t5_mdo", 64'(mdo0), 1);
        chk("t5_ack", 64'(ack0), 0);
        repeat (60) @(negedge clk);
        rst_n = 1;
        repeat (3) @(negedge clk);
        req(0, 0, {5'd1, 5'd2}, 16'h0, 1, 0, 1, 16'hBEEF);
        wait_resp(0, 4000);
        repeat (3) @(negedge clk);

        // 6: cyc dropped in HDR; new request the cycle after DONE
        s = n0;
        req(0, 1, {5'd1, 5'd5}, 16'h0F0F, 0, 0, 0, 16'h0);
        repeat (1850) @(negedge clk);
        cyc0 = 0; stb0 = 0;
        begin
            int k;
            for (k = 0; k < 4000; k++) begin
                @(negedge clk);
                if (!oe0) break;
            end
            if (k == 4000) chk("t6_done_timeout", 64'(oe0), 0);
        end
        chk("t6_bits", 64'(n0 - s), 64);
        chk("t6_frame", 64'(cap0[31:0]), 64'({2'b01, 2'b01, 5'd1, 5'd5, 2'b10, 16'h0F0F}));
        req(0, 1, {5'd1, 5'd6}, 16'h00FF, 1, 0, 0, 16'h0);
        @(negedge clk);
        chk("t6_accept", 64'(oe0), 1);
        wait_resp(0, 4000);
        chk("t6_phyreg5", 64'(phy_regs[5]), 64'h0F0F);
        chk("t6_phyreg6", 64'(phy_regs[6]), 64'h00FF);

        repeat (20) @(negedge clk);
        chk("sb0_empty", 64'(q0.size()), 0);
        chk("sb1_empty", 64'(q1.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
